// File: rtl/fetch_decode_ctrl.sv
// ============================================================================
// fetch_decode_ctrl : instruction fetch / decode / issue sequencer
// Rev 1.0
// ============================================================================
`default_nettype none

module fetch_decode_ctrl #(
  parameter logic [7:0] MAX_ADDR = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] prog_sel,
  output logic [1:0] prog,
  output logic [7:0] address,
  input  logic [7:0] instruction,
  input  logic       exec_ready,
  output logic       op_valid,
  output logic [3:0] op_code,
  output logic [1:0] op_ra,
  output logic [1:0] op_rb,
  output logic       alu_en,
  output logic       push_en,
  output logic       lda_en,
  output logic       ldb_en,
  output logic       out_en,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] instr_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] ir;
  logic       is_nop;
  logic       is_out;
  logic       leave_issue;

  assign is_nop      = (ir[7:5] == 3'b111);
  assign is_out      = (ir[7:4] == 4'b1011);
  // NOPs never wait on the execute stage
  assign leave_issue = (state == ISSUE) && (is_nop || exec_ready);

  assign op_code  = ir[7:4];
  assign op_ra    = ir[3:2];
  assign op_rb    = ir[1:0];
  assign op_valid = (state == ISSUE) && !is_nop;
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = FETCH;
      FETCH: state_next = ISSUE;
      ISSUE: begin
        if (leave_issue) begin
          if (is_out || (address == MAX_ADDR)) state_next = DONE;
          else                                 state_next = FETCH;
        end
      end
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    alu_en  = 1'b0;
    push_en = 1'b0;
    lda_en  = 1'b0;
    ldb_en  = 1'b0;
    out_en  = 1'b0;
    if (op_valid) begin
      case (ir[7:4])
        4'b1000: push_en = 1'b1;
        4'b1001: lda_en  = 1'b1;
        4'b1010: ldb_en  = 1'b1;
        4'b1011: out_en  = 1'b1;
        default: alu_en  = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prog        <= 2'd0;
      address     <= 8'd0;
      ir          <= 8'd0;
      err         <= 1'b0;
      instr_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            address     <= 8'd0;
            prog        <= prog_sel;
            instr_count <= 8'd0;
            err         <= 1'b0;
          end
        end
        FETCH: ir <= instruction;
        ISSUE: begin
          if (op_valid && exec_ready) instr_count <= instr_count + 8'd1;
          if (leave_issue && !is_out) begin
            if (address == MAX_ADDR) err <= 1'b1;
            else                     address <= address + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_ctrl.sv
// ============================================================================
// tb_fetch_decode_ctrl : scoreboard bench for fetch_decode_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_fetch_decode_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] prog_sel;
  logic [1:0] prog;
  logic [7:0] address;
  logic [7:0] instruction;
  logic       exec_ready;
  logic       op_valid;
  logic [3:0] op_code;
  logic [1:0] op_ra, op_rb;
  logic       alu_en, push_en, lda_en, ldb_en, out_en;
  logic       busy, done, err;
  logic [7:0] instr_count;
  logic [4:0] strb;

  logic       start2;
  logic [1:0] prog2;
  logic [7:0] address2;
  logic [7:0] instruction2;
  logic       op_valid2;
  logic [3:0] op_code2;
  logic [1:0] op_ra2, op_rb2;
  logic       alu_en2, push_en2, lda_en2, ldb_en2, out_en2;
  logic       busy2, done2, err2;
  logic [7:0] instr_count2;

  logic [7:0] rom [0:255];

  typedef struct {
    logic [3:0] code;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [4:0] strb;
  } op_t;

  typedef struct {
    logic [7:0] cnt;
    logic       err;
    logic [7:0] addr;
    logic [1:0] prog;
    int         lat;
  } end_t;

  op_t  exp_ops [$];
  end_t exp_end [$];
  op_t  e_op;
  end_t e_end;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;
  int push_cnt2 = 0;
  bit seen;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign instruction  = rom[address];
  assign instruction2 = 8'h80;
  assign strb = {alu_en, push_en, lda_en, ldb_en, out_en};

  fetch_decode_ctrl u_dut (
    .clk(clk), .rst(rst), .start(start), .prog_sel(prog_sel), .prog(prog),
    .address(address), .instruction(instruction), .exec_ready(exec_ready),
    .op_valid(op_valid), .op_code(op_code), .op_ra(op_ra), .op_rb(op_rb),
    .alu_en(alu_en), .push_en(push_en), .lda_en(lda_en), .ldb_en(ldb_en),
    .out_en(out_en), .busy(busy), .done(done), .err(err),
    .instr_count(instr_count)
  );

  fetch_decode_ctrl #(.MAX_ADDR(8'd3)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .prog_sel(2'd2), .prog(prog2),
    .address(address2), .instruction(instruction2), .exec_ready(1'b1),
    .op_valid(op_valid2), .op_code(op_code2), .op_ra(op_ra2), .op_rb(op_rb2),
    .alu_en(alu_en2), .push_en(push_en2), .lda_en(lda_en2), .ldb_en(ldb_en2),
    .out_en(out_en2), .busy(busy2), .done(done2), .err(err2),
    .instr_count(instr_count2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic exp_op(input logic [3:0] c, input logic [1:0] a, input logic [1:0] b,
                        input logic [4:0] s);
    op_t o;
    o.code = c; o.ra = a; o.rb = b; o.strb = s;
    exp_ops.push_back(o);
  endtask

  // Strobe order in expectations: {alu, push, lda, ldb, out}
  task automatic push_prog(input bit skip_third, input int lat);
    end_t f;
    exp_op(4'h9, 2'd0, 2'd0, 5'b00100);
    exp_op(4'hA, 2'd1, 2'd0, 5'b00010);
    if (!skip_third) exp_op(4'h0, 2'd0, 2'd1, 5'b10000);
    exp_op(4'h8, 2'd0, 2'd0, 5'b01000);
    exp_op(4'h5, 2'd0, 2'd0, 5'b10000);
    exp_op(4'h8, 2'd0, 2'd0, 5'b01000);
    exp_op(4'hB, 2'd0, 2'd0, 5'b00001);
    f.cnt = skip_third ? 8'd6 : 8'd7; f.err = 1'b0; f.addr = 8'd6; f.prog = 2'd1; f.lat = lat;
    exp_end.push_back(f);
  endtask

  task automatic load_rom();
    for (int i = 0; i < 256; i++) rom[i] = 8'hB0;
    rom[0] = 8'h90; rom[1] = 8'hA4; rom[2] = 8'h01; rom[3] = 8'h80;
    rom[4] = 8'h50; rom[5] = 8'h80; rom[6] = 8'hB0;
  endtask

  task automatic do_start(input logic [1:0] ps);
    start = 1'b1;
    prog_sel = ps;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    seen = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin seen = 1'b1; break; end
    end
    chk({nm, "_done_seen"}, {31'd0, seen}, 32'd1);
    @(negedge clk);
    chk({nm, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string nm);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (op_valid) begin seen = 1'b1; break; end
    end
    chk({nm, "_valid_seen"}, {31'd0, seen}, 32'd1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (op_valid && exec_ready) begin
        if (exp_ops.size() == 0) begin
          chk("unexpected_op", 32'd1, 32'd0);
        end else begin
          e_op = exp_ops.pop_front();
          chk("op_code", {28'd0, op_code}, {28'd0, e_op.code});
          chk("op_ra",   {30'd0, op_ra},   {30'd0, e_op.ra});
          chk("op_rb",   {30'd0, op_rb},   {30'd0, e_op.rb});
          chk("strobes", {27'd0, strb},    {27'd0, e_op.strb});
        end
      end
      if (!op_valid) chk("idle_strobes", {27'd0, strb}, 32'd0);
      if (done) begin
        if (exp_end.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e_end = exp_end.pop_front();
          chk("end_count", {24'd0, instr_count}, {24'd0, e_end.cnt});
          chk("end_err",   {31'd0, err},         {31'd0, e_end.err});
          chk("end_addr",  {24'd0, address},     {24'd0, e_end.addr});
          chk("end_prog",  {30'd0, prog},        {30'd0, e_end.prog});
          chk("end_ops_left", exp_ops.size(), 32'd0);
          if (e_end.lat >= 0) chk("done_latency", cyc - start_cyc, e_end.lat);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && op_valid2 && push_en2) push_cnt2 <= push_cnt2 + 1;
  end

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0; prog_sel = 2'd0; exec_ready = 1'b1;
    load_rom();
    #3;
    chk("rst_outputs", {prog, address, op_valid, op_code, op_ra, op_rb},   32'd0);
    chk("rst_status",  {strb, busy, done, err, instr_count}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Baseline program, execute always ready
    push_prog(1'b0, 15);
    do_start(2'd1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("prog_captured", {30'd0, prog}, 32'd1);
    wait_done("t1");

    // Stall the third issue for three cycles
    push_prog(1'b0, 18);
    do_start(2'd1);
    for (int i = 0; i < 40; i++) begin
      if (instr_count == 8'd2) break;
      @(posedge clk); #1;
    end
    chk("t2_count_two", {24'd0, instr_count}, 32'd2);
    exec_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exec_ready = 1'b1;
      @(negedge clk);
      chk("stall_hold", {op_valid, op_code, op_ra, op_rb}, {24'd0, 1'b1, 4'h0, 2'd0, 2'd1});
      if (i < 3) begin @(posedge clk); #1; end
    end
    wait_done("t2");

    // NOP in place of the third instruction
    rom[2] = 8'hF0;
    push_prog(1'b1, 15);
    do_start(2'd1);
    wait_done("t3");
    rom[2] = 8'h01;

    // start with a new prog_sel while busy must be ignored
    push_prog(1'b0, 15);
    do_start(2'd1);
    wait_valid("t5");
    start = 1'b1; prog_sel = 2'd3;
    @(posedge clk); #1;
    start = 1'b0; prog_sel = 2'd0;
    chk("prog_hold", {30'd0, prog}, 32'd1);
    wait_done("t5");

    // Asynchronous reset during ISSUE, then a clean restart
    push_prog(1'b0, 15);
    do_start(2'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    wait_valid("t6");
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid_busy", {30'd0, op_valid, busy}, 32'd0);
    chk("async_rst_addr_cnt", {address, instr_count}, 32'd0);
    exp_ops.delete();
    exp_end.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_prog(1'b0, 15);
    do_start(2'd1);
    chk("restart_addr", {24'd0, address}, 32'd0);
    wait_done("t6");

    // MAX_ADDR=3 instance, no out instruction -> error end
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done2) begin seen = 1'b1; break; end
    end
    chk("t4_done_seen", {31'd0, seen}, 32'd1);
    chk("t4_err", {31'd0, err2}, 32'd1);
    chk("t4_addr", {24'd0, address2}, 32'd3);
    chk("t4_count", {24'd0, instr_count2}, 32'd4);
    chk("t4_pushes", push_cnt2, 32'd4);
    @(negedge clk);
    chk("t4_idle_err_hold", {29'd0, busy2, done2, err2}, 32'd1);

    chk("ops_drained", exp_ops.size(), 32'd0);
    chk("ends_drained", exp_end.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
